// File: rtl/audio_word_streamer.sv
// Packs AC97 samples into memory words for recording and unpacks memory words
// into a sample stream for playback; word_adv pulses drive the address calculator.
module audio_word_streamer #(
    parameter int SAMPLE_W         = 12,
    parameter int SAMPLES_PER_WORD = 3,
    parameter int BANK_BITS        = 1,
    localparam int NUM_BANKS       = 1 << BANK_BITS,
    localparam int WORD_W          = SAMPLE_W * SAMPLES_PER_WORD
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ready,
    input  logic [SAMPLE_W-1:0]         audio_in,
    input  logic                        start_song,
    input  logic [BANK_BITS-1:0]        bank_sel,
    input  logic                        record_mode,
    input  logic                        pause_song,
    input  logic                        song_done,
    input  logic [NUM_BANKS*WORD_W-1:0] mem_read,
    output logic [WORD_W-1:0]           mem_write,
    output logic [NUM_BANKS-1:0]        we,
    output logic [SAMPLE_W-1:0]         audio_out,
    output logic                        word_adv,
    output logic                        busy
);
    localparam int SLOT_W = $clog2(SAMPLES_PER_WORD);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SAMPLES_PER_WORD - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] PRIME = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]           state_r, state_s;
    logic [SLOT_W-1:0]    slot_r, slot_s;
    logic [WORD_W-1:0]    wr_buf_r, wr_buf_s;
    logic [WORD_W-1:0]    play_buf_r, play_buf_s;
    logic [WORD_W-1:0]    mem_write_r, mem_write_s;
    logic [NUM_BANKS-1:0] we_r, we_s;
    logic [SAMPLE_W-1:0]  audio_out_r, audio_out_s;
    logic                 word_adv_r, word_adv_s;
    logic                 busy_r, busy_s;
    logic                 mode_r, mode_s;
    logic [BANK_BITS-1:0] bank_r, bank_s;

    logic [WORD_W-1:0]    bank_word_s [NUM_BANKS];
    logic [WORD_W-1:0]    sel_word_s;
    logic [NUM_BANKS-1:0] we_mask_s;
    logic [WORD_W-1:0]    wr_shift_s;
    logic [WORD_W-1:0]    flush_word_s;
    logic [WORD_W-1:0]    play_shift_s;
    logic [SAMPLE_W-1:0]  play_sample_s;
    logic [SLOT_W-1:0]    slot_inc_s;

    // Bank slicing, sample extraction and packing helpers
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_word_s[b] = mem_read[b*WORD_W +: WORD_W];
        end
        sel_word_s    = bank_word_s[bank_r];
        we_mask_s     = {{(NUM_BANKS-1){1'b0}}, 1'b1} << bank_r;
        wr_shift_s    = {wr_buf_r[WORD_W-SAMPLE_W-1:0], audio_in};
        // Partial word is left-aligned so unused slots read back as zero samples
        flush_word_s  = wr_buf_r << ((SAMPLES_PER_WORD - 32'(slot_r)) * SAMPLE_W);
        play_shift_s  = play_buf_r << (32'(slot_r) * SAMPLE_W);
        play_sample_s = play_shift_s[WORD_W-1 -: SAMPLE_W];
        slot_inc_s    = (slot_r == LAST_SLOT) ? {SLOT_W{1'b0}} : slot_r + SLOT_W'(1);
    end

    // Next-state and next-output computation
    always_comb begin
        state_s     = state_r;
        slot_s      = slot_r;
        wr_buf_s    = wr_buf_r;
        play_buf_s  = play_buf_r;
        mem_write_s = mem_write_r;
        we_s        = {NUM_BANKS{1'b0}};
        word_adv_s  = 1'b0;
        audio_out_s = audio_out_r;
        mode_s      = mode_r;
        bank_s      = bank_r;
        if (start_song) begin
            state_s = PRIME;
            slot_s  = {SLOT_W{1'b0}};
            mode_s  = record_mode;
            bank_s  = bank_sel;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                PRIME: begin
                    if (mode_r) begin
                        wr_buf_s = {WORD_W{1'b0}};
                    end else begin
                        play_buf_s = sel_word_s;
                        word_adv_s = 1'b1;
                    end
                    state_s = RUN;
                    slot_s  = {SLOT_W{1'b0}};
                end
                RUN: begin
                    if (song_done) begin
                        if (mode_r && (slot_r != {SLOT_W{1'b0}})) begin
                            state_s = FLUSH;
                        end else begin
                            state_s     = DONE;
                            audio_out_s = {SAMPLE_W{1'b0}};
                        end
                    end else if (ready && !pause_song) begin
                        slot_s = slot_inc_s;
                        if (mode_r) begin
                            audio_out_s = audio_in;
                            wr_buf_s    = wr_shift_s;
                            if (slot_r == LAST_SLOT) begin
                                mem_write_s = wr_shift_s;
                                we_s        = we_mask_s;
                                word_adv_s  = 1'b1;
                            end else begin
                                mem_write_s = mem_write_r;
                            end
                        end else begin
                            audio_out_s = play_sample_s;
                            if (slot_r == LAST_SLOT) begin
                                play_buf_s = sel_word_s;
                                word_adv_s = 1'b1;
                            end else begin
                                play_buf_s = play_buf_r;
                            end
                        end
                    end else begin
                        slot_s = slot_r;
                    end
                end
                FLUSH: begin
                    mem_write_s = flush_word_s;
                    we_s        = we_mask_s;
                    state_s     = DONE;
                    audio_out_s = {SAMPLE_W{1'b0}};
                end
                DONE: begin
                    audio_out_s = {SAMPLE_W{1'b0}};
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
        busy_s = (state_s == PRIME) || (state_s == RUN) || (state_s == FLUSH);
    end

    // State, context and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            slot_r      <= {SLOT_W{1'b0}};
            wr_buf_r    <= {WORD_W{1'b0}};
            play_buf_r  <= {WORD_W{1'b0}};
            mem_write_r <= {WORD_W{1'b0}};
            we_r        <= {NUM_BANKS{1'b0}};
            audio_out_r <= {SAMPLE_W{1'b0}};
            word_adv_r  <= 1'b0;
            busy_r      <= 1'b0;
            mode_r      <= record_mode;
            bank_r      <= bank_sel;
        end else begin
            state_r     <= state_s;
            slot_r      <= slot_s;
            wr_buf_r    <= wr_buf_s;
            play_buf_r  <= play_buf_s;
            mem_write_r <= mem_write_s;
            we_r        <= we_s;
            audio_out_r <= audio_out_s;
            word_adv_r  <= word_adv_s;
            busy_r      <= busy_s;
            mode_r      <= mode_s;
            bank_r      <= bank_s;
        end
    end

    assign mem_write = mem_write_r;
    assign we        = we_r;
    assign audio_out = audio_out_r;
    assign word_adv  = word_adv_r;
    assign busy      = busy_r;

endmodule

// File: doc/audio_word_streamer.md
# audio_word_streamer

Parametrised successor to the ZBT audio translator between the AC97 sample stream and the ZBT memory banks. Packs `SAMPLES_PER_WORD` samples of `SAMPLE_W` bits into one memory word for recording, and unpacks words into a sample stream for playback. Supports any power-of-two bank count and primes the first playback word before audio starts. Flushes a zero-padded partial word when a recording ends mid-word. Address generation stays in the address calculator; this block only issues one-cycle `word_adv` pulses to it.

## Interface
- `SAMPLE_W`, 12, bits per audio sample.
- `SAMPLES_PER_WORD`, 3, samples packed per memory word (≥2); `WORD_W` = `SAMPLE_W*SAMPLES_PER_WORD` (derived, not overridable).
- `BANK_BITS`, 1, bank select width; `NUM_BANKS` = 2^`BANK_BITS`.

- `clk` input 1: system clock; single clock domain.
- `reset` input 1: synchronous, active-high.
- `ready` input 1: one-cycle strobe per AC97 sample.
- `audio_in` input `SAMPLE_W`: sample from AC97, valid when `ready`.
- `start_song` input 1: one-cycle strobe; (re)starts a song in any state.
- `bank_sel` input `BANK_BITS`: bank for the song, latched on `start_song`.
- `record_mode` input 1: 1 = record, 0 = playback; latched on `start_song`.
- `pause_song` input 1: level; freezes all progress.
- `song_done` input 1: level from address calculator; end of song region.
- `mem_read` input `NUM_BANKS*WORD_W`: bank b read data at bits [b*WORD_W +: WORD_W].
- `mem_write` output `WORD_W`: write data, common to all banks.
- `we` output `NUM_BANKS`: one-hot write enable, bit = latched bank.
- `audio_out` output `SAMPLE_W`: sample to the speaker path.
- `word_adv` output 1: one-cycle pulse; the address calculator advances by one word.
- `busy` output 1: high in PRIME, RUN, FLUSH.

## Operation
- Latched context: `mode` (record_mode) and `bank` (bank_sel), captured on every `start_song` and on `reset`.
- Internal: `slot` counter 0..SPW-1; `wr_buf` (WORD_W); `play_buf` (WORD_W).
- States:
  - IDLE (reset state).
  - PRIME: lasts one cycle.
    - Playback: `play_buf` <= `mem_read[bank]`; `word_adv` pulses.
    - Record: `wr_buf` <= 0.
    - Next state: RUN; `slot` <= 0.
  - RUN: acts only on `ready & ~pause_song & ~song_done`.
    - Playback: `audio_out` <= sample `slot` of `play_buf`, MSB-first (slot 0 = bits [WORD_W-1 -: SAMPLE_W]). At `slot`==SPW-1: `play_buf` <= `mem_read[bank]` and `word_adv` pulses.
    - Record: `audio_out` <= `audio_in` (monitor); `wr_buf` <= {wr_buf[WORD_W-SAMPLE_W-1:0], audio_in}. At `slot`==SPW-1: `mem_write` <= that shifted value; `we[bank]` and `word_adv` pulse.
    - `slot` increments and wraps SPW-1 -> 0.
    - `song_done` high: record with `slot`≠0 -> FLUSH; otherwise -> DONE.
  - FLUSH: `mem_write` <= `wr_buf` << ((SPW-slot)*SAMPLE_W), i.e. zero-padded at the LSB end; `we[bank]` pulses; no `word_adv`. Next state: DONE.
  - DONE: `audio_out` held at 0; waits for `start_song`.
- `start_song` has priority over everything in any state, including mid-FLUSH: go to PRIME, `slot` <= 0, no write issued in that cycle.
- `pause_song` in RUN: `ready` is ignored; `slot`, buffers and `audio_out` are held; no `we` or `word_adv`. `song_done` is still checked.
- Simultaneous `ready` and `song_done` in RUN: the sample is dropped and the `song_done` transition is taken.
- `we` is never asserted in playback; never more than one `we` bit is high.

## Timing
- Reset values: `mem_write`=0, `we`=0, `audio_out`=0, `word_adv`=0, `busy`=0, `slot`=0, both buffers 0, state IDLE, `mode`=`record_mode`, `bank`=`bank_sel`.
- All outputs are registered.
  - `audio_out` updates on the edge that samples `ready`, so it is visible the following cycle.
  - `we`/`word_adv`/`mem_write` are valid for exactly the one cycle after the completing `ready` edge.
- Playback latency: the first audible sample is word 0, slot 0, emitted on the first `ready` after PRIME. There is no leading zero word.
- `mem_read[bank]` must be stable at PRIME and at every slot SPW-1 `ready` edge. The address calculator has at least SPW `ready` periods after `word_adv` to present the next word.
- FLUSH `we` occurs 2 cycles after the edge at which `song_done` is seen in RUN.

## Test plan
- Record, SPW=3, W=12, bank_sel=1: samples 0x111, 0x222, 0x333 -> one-cycle `we`=2'b10, `mem_write`=0x111222333, `word_adv`=1 in the same cycle; `we` stays 0 for the first two samples.
- Playback, bank 0, `mem_read0`=0xABC123456 at PRIME -> `word_adv` pulses at PRIME; the next three `ready` produce `audio_out` 0xABC, 0x123, 0x456; `word_adv` pulses on the third; `we` stays 0.
- Record 0x00A, 0x00B, then raise `song_done` -> FLUSH writes `mem_write`=0x00A00B000 with a single `we` pulse; state DONE; `busy`=0.
- `pause_song` high across 5 `ready` strobes mid-word -> no output change, no `we`/`word_adv`; after release, packing resumes at the held `slot`.
- `start_song` (playback) during record RUN at `slot`=1 -> no `we`, PRIME the next cycle, `slot`=0; `reset` mid-RUN -> all outputs 0 the next cycle.
- BANK_BITS=2, bank_sel=3, record one word -> only `we[3]` pulses; `mem_read` slices of other banks are ignored in playback.
